// File: rtl/sram_sequencer_if.sv
// Request/response channel between the RAM controller and one sram_sequencer.
// Handshake: a request is a new token on mem_act while need_to_work and (mem_rd | mem_wr) are high; it is closed when done_act equals that token.
interface sram_sequencer_if;
    logic        need_to_work;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [31:0] mem_act;
    logic [31:0] done_act;
    logic [15:0] feedback;
    logic        busy;

    modport master (
        output need_to_work, mem_rd, mem_wr, addr, wdata, mem_act,
        input  done_act, feedback, busy
    );

    modport slave (
        input  need_to_work, mem_rd, mem_wr, addr, wdata, mem_act,
        output done_act, feedback, busy
    );
endinterface

// File: rtl/sram_sequencer.sv
// Cycle-level access sequencer for one asynchronous 16-bit SRAM chip.
// Every chip pin is driven from a flop, so strobes and address never glitch.
module sram_sequencer #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    sram_sequencer_if.slave         req,
    output logic [17:0]             ram_addr,
    inout  wire  [15:0]             ram_data,
    output logic                    ram_en_n,
    output logic                    ram_oe_n,
    output logic                    ram_we_n,
    output logic [2:0]              dbg_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_WAIT  = 3'd1,
        WR_SETUP = 3'd2,
        WR_PULSE = 3'd3,
        WR_HOLD  = 3'd4,
        DONE     = 3'd5
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t      state;
    logic [3:0]  cnt;
    logic [15:0] wdata_q;
    logic [31:0] act_q;
    logic [31:0] done_q;
    logic [15:0] feedback_q;
    logic        data_oe;
    logic        accept;

    // A token equal to the last completed one is never re-executed.
    assign accept = req.need_to_work && (req.mem_rd || req.mem_wr) &&
                    (req.mem_act != done_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            wdata_q    <= 16'h0000;
            act_q      <= 32'h0000_0000;
            done_q     <= 32'hffff_ffff;
            feedback_q <= 16'h0000;
            ram_addr   <= 18'h0_0000;
            ram_en_n   <= 1'b1;
            ram_oe_n   <= 1'b1;
            ram_we_n   <= 1'b1;
            data_oe    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        wdata_q  <= req.wdata;
                        act_q    <= req.mem_act;
                        ram_addr <= {2'b00, req.addr};
                        ram_en_n <= 1'b0;
                        if (req.mem_wr) begin
                            state   <= WR_SETUP;
                            data_oe <= 1'b1;
                        end else begin
                            state    <= RD_WAIT;
                            ram_oe_n <= 1'b0;
                            cnt      <= WAIT_LOAD;
                        end
                    end
                end
                RD_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        feedback_q <= ram_data;
                        done_q     <= act_q;
                        ram_en_n   <= 1'b1;
                        ram_oe_n   <= 1'b1;
                        state      <= DONE;
                    end
                end
                WR_SETUP: begin
                    ram_we_n <= 1'b0;
                    cnt      <= WAIT_LOAD;
                    state    <= WR_PULSE;
                end
                WR_PULSE: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        ram_we_n <= 1'b1;
                        state    <= WR_HOLD;
                    end
                end
                WR_HOLD: begin
                    // Data stays on the bus through this cycle to cover hold time.
                    done_q   <= act_q;
                    ram_en_n <= 1'b1;
                    data_oe  <= 1'b0;
                    state    <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ram_data     = data_oe ? wdata_q : 16'hzzzz;
    assign req.done_act = done_q;
    assign req.feedback = feedback_q;
    assign req.busy     = (state != IDLE);
    assign dbg_state    = state;

endmodule

// File: tb/tb_sram_sequencer.sv
// Bench for sram_sequencer: three instances (WAIT 0, 1, 15) share one request stream,
// each with its own SRAM model; directed vectors plus reset and repeated-token sequences.
module tb_sram_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        need_to_work;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [31:0] mem_act;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;
    int c0;

    localparam int wait_of[3] = '{0, 1, 15};

    sram_sequencer_if if0 ();
    sram_sequencer_if if1 ();
    sram_sequencer_if if15 ();

    assign if0.need_to_work  = need_to_work;
    assign if0.mem_rd        = mem_rd;
    assign if0.mem_wr        = mem_wr;
    assign if0.addr          = addr;
    assign if0.wdata         = wdata;
    assign if0.mem_act       = mem_act;
    assign if1.need_to_work  = need_to_work;
    assign if1.mem_rd        = mem_rd;
    assign if1.mem_wr        = mem_wr;
    assign if1.addr          = addr;
    assign if1.wdata         = wdata;
    assign if1.mem_act       = mem_act;
    assign if15.need_to_work = need_to_work;
    assign if15.mem_rd       = mem_rd;
    assign if15.mem_wr       = mem_wr;
    assign if15.addr         = addr;
    assign if15.wdata        = wdata;
    assign if15.mem_act      = mem_act;

    wire  [15:0] ram_data0, ram_data1, ram_data15;
    logic [17:0] ram_addr0, ram_addr1, ram_addr15;
    logic        en0, oe0, we0, en1, oe1, we1, en15, oe15, we15;
    logic [2:0]  dbg0, dbg1, dbg15;

    sram_sequencer #(.WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .req(if0), .ram_addr(ram_addr0), .ram_data(ram_data0),
        .ram_en_n(en0), .ram_oe_n(oe0), .ram_we_n(we0), .dbg_state(dbg0)
    );
    sram_sequencer #(.WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst), .req(if1), .ram_addr(ram_addr1), .ram_data(ram_data1),
        .ram_en_n(en1), .ram_oe_n(oe1), .ram_we_n(we1), .dbg_state(dbg1)
    );
    sram_sequencer #(.WAIT_CYCLES(15)) u_w15 (
        .clk(clk), .rst(rst), .req(if15), .ram_addr(ram_addr15), .ram_data(ram_data15),
        .ram_en_n(en15), .ram_oe_n(oe15), .ram_we_n(we15), .dbg_state(dbg15)
    );

    // Per-instance views, index 0/1/2 = WAIT 0/1/15.
    logic [31:0] done_v[3];
    logic [15:0] fb_v[3];
    logic [15:0] data_v[3];
    logic [17:0] addr_v[3];
    logic        en_v[3], oe_v[3], we_v[3], busy_v[3], drv_v[3];
    logic [2:0]  dbg_v[3];

    always_comb begin
        done_v[0] = if0.done_act;  done_v[1] = if1.done_act;  done_v[2] = if15.done_act;
        fb_v[0]   = if0.feedback;  fb_v[1]   = if1.feedback;  fb_v[2]   = if15.feedback;
        busy_v[0] = if0.busy;      busy_v[1] = if1.busy;      busy_v[2] = if15.busy;
        data_v[0] = ram_data0;     data_v[1] = ram_data1;     data_v[2] = ram_data15;
        addr_v[0] = ram_addr0;     addr_v[1] = ram_addr1;     addr_v[2] = ram_addr15;
        en_v[0]   = en0;           en_v[1]   = en1;           en_v[2]   = en15;
        oe_v[0]   = oe0;           oe_v[1]   = oe1;           oe_v[2]   = oe15;
        we_v[0]   = we0;           we_v[1]   = we1;           we_v[2]   = we15;
        dbg_v[0]  = dbg0;          dbg_v[1]  = dbg1;          dbg_v[2]  = dbg15;
        drv_v[0]  = u_w0.data_oe;  drv_v[1]  = u_w1.data_oe;  drv_v[2]  = u_w15.data_oe;
    end

    // SRAM models: write while en_n and we_n are low, drive the bus during en_n & oe_n low.
    logic [15:0] mem [3][65536];
    bit preload;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (preload) mem[i][16'hffff] <= 16'hc3c3;
            else if (!en_v[i] && !we_v[i]) mem[i][addr_v[i][15:0]] <= data_v[i];
        end
    end

    assign ram_data0  = (!en0 && !oe0 && we0)    ? mem[0][ram_addr0[15:0]]  : 16'hzzzz;
    assign ram_data1  = (!en1 && !oe1 && we1)    ? mem[1][ram_addr1[15:0]]  : 16'hzzzz;
    assign ram_data15 = (!en15 && !oe15 && we15) ? mem[2][ram_addr15[15:0]] : 16'hzzzz;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitors sampled on the falling edge.
    int          we_lo[3], act_cnt[3], ovl[3], done_cyc[3];
    logic [31:0] done_prev[3];
    int          snap_we[3], snap_act[3], snap_ovl[3];

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!we_v[i]) we_lo[i] <= we_lo[i] + 1;
            if (!en_v[i]) act_cnt[i] <= act_cnt[i] + 1;
            if (!oe_v[i] && (drv_v[i] || !we_v[i])) ovl[i] <= ovl[i] + 1;
            if (done_v[i] != done_prev[i]) done_cyc[i] <= cyc;
            done_prev[i] <= done_v[i];
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic snapshot();
        for (int i = 0; i < 3; i++) begin
            snap_we[i]  = we_lo[i];
            snap_act[i] = act_cnt[i];
            snap_ovl[i] = ovl[i];
        end
    endtask

    task automatic start_req(input logic rd, input logic wr, input logic [15:0] a,
                             input logic [15:0] d, input logic [31:0] act);
        @(negedge clk);
        snapshot();
        mem_rd       = rd;
        mem_wr       = wr;
        addr         = a;
        wdata        = d;
        mem_act      = act;
        need_to_work = 1'b1;
        c0           = cyc + 1;
    endtask

    task automatic finish_req(input logic [31:0] act);
        int t;
        t = 0;
        while (!(done_v[0] == act && done_v[1] == act && done_v[2] == act) && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (t >= 60) check("done timeout", done_v[2], act);
        need_to_work = 1'b0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        t = 0;
        while ((busy_v[0] || busy_v[1] || busy_v[2]) && t < 10) begin
            @(negedge clk);
            t++;
        end
        if (t >= 10) check("idle timeout", 32'(busy_v[2]), 32'd0);
        @(negedge clk);
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] a;
        logic [15:0] d;
        logic [31:0] act;
        logic [15:0] exp_fb;
        bit          trace;
    } vec_t;

    vec_t vecs[9];

    task automatic check_vec(input int idx, input vec_t v);
        int w;
        for (int k = 0; k < 3; k++) begin
            w = wait_of[k];
            check($sformatf("v%0d w%0d done_act", idx, w), done_v[k], v.act);
            check($sformatf("v%0d w%0d feedback", idx, w), 32'(fb_v[k]), 32'(v.exp_fb));
            check($sformatf("v%0d w%0d we_cycles", idx, w), 32'(we_lo[k] - snap_we[k]),
                  v.wr ? 32'(w + 1) : 32'd0);
            check($sformatf("v%0d w%0d latency", idx, w), 32'(done_cyc[k] - c0),
                  v.wr ? 32'(w + 3) : 32'(w + 1));
            check($sformatf("v%0d w%0d oe_overlap", idx, w), 32'(ovl[k] - snap_ovl[k]), 32'd0);
            check($sformatf("v%0d w%0d ram_addr", idx, w), 32'(addr_v[k]), {16'h0000, v.a});
        end
    endtask

    // Cycle trace of a WAIT=1 write: {en_n, oe_n, we_n, drive, busy} and done_act.
    task automatic trace_w1(input vec_t v);
        logic [4:0]  exp_pins[6];
        logic [31:0] exp_done[6];
        exp_pins = '{5'b01111, 5'b01011, 5'b01011, 5'b01111, 5'b11101, 5'b11100};
        exp_done = '{32'hffff_ffff, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_ffff, v.act, v.act};
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check($sformatf("trace c%0d pins", j), 32'({en_v[1], oe_v[1], we_v[1], drv_v[1], busy_v[1]}),
                  32'(exp_pins[j]));
            check($sformatf("trace c%0d done_act", j), done_v[1], exp_done[j]);
            if (exp_pins[j][1]) check($sformatf("trace c%0d bus", j), 32'(data_v[1]), 32'(v.d));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   t;
        vecs[0] = '{1'b0, 1'b1, 16'h8003, 16'hbeef, 32'd5,  16'h0000, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 16'h8003, 16'h0000, 32'd6,  16'hbeef, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 16'h0042, 16'ha5a5, 32'd7,  16'hbeef, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 16'h0042, 16'h0000, 32'd9,  16'ha5a5, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 16'h0000, 16'h0001, 32'd10, 16'ha5a5, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 16'hffff, 16'h0000, 32'd11, 16'hc3c3, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 32'd12, 16'h0001, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 16'hffff, 16'h0000, 32'd13, 16'h0001, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 16'hffff, 16'h0000, 32'd14, 16'h0000, 1'b0};

        preload      = 1'b1;
        rst          = 1'b1;
        need_to_work = 1'b0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        addr         = 16'h0000;
        wdata        = 16'h0000;
        mem_act      = 32'd0;
        repeat (2) @(negedge clk);
        preload = 1'b0;
        rst     = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset w%0d done_act", wait_of[k]), done_v[k], 32'hffff_ffff);
            check($sformatf("reset w%0d feedback", wait_of[k]), 32'(fb_v[k]), 32'd0);
            check($sformatf("reset w%0d pins", wait_of[k]),
                  32'({en_v[k], oe_v[k], we_v[k], drv_v[k], busy_v[k]}), 32'(5'b11100));
            check($sformatf("reset w%0d ram_addr", wait_of[k]), 32'(addr_v[k]), 32'd0);
            check($sformatf("reset w%0d state", wait_of[k]), 32'(dbg_v[k]), 32'd0);
        end

        for (int i = 0; i < 9; i++) begin
            v = vecs[i];
            start_req(v.rd, v.wr, v.a, v.d, v.act);
            if (v.trace) trace_w1(v);
            finish_req(v.act);
            check_vec(i, v);
        end

        // Completed token held with need_to_work high: nothing may start.
        @(negedge clk);
        snapshot();
        mem_rd       = 1'b1;
        mem_act      = 32'd14;
        need_to_work = 1'b1;
        repeat (20) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("repeat w%0d strobe_cycles", wait_of[k]), 32'(act_cnt[k] - snap_act[k]), 32'd0);
            check($sformatf("repeat w%0d busy", wait_of[k]), 32'(busy_v[k]), 32'd0);
        end
        need_to_work = 1'b0;
        mem_rd       = 1'b0;

        // Reset during the write pulse aborts without completing the token.
        start_req(1'b0, 1'b1, 16'h0077, 16'h7777, 32'd7);
        t = 0;
        while (we_v[1] && t < 10) begin
            @(negedge clk);
            t++;
        end
        if (t >= 10) check("midwrite pulse timeout", 32'(we_v[1]), 32'd0);
        rst          = 1'b1;
        need_to_work = 1'b0;
        mem_wr       = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("midrst w%0d pins", wait_of[k]),
                  32'({en_v[k], oe_v[k], we_v[k], drv_v[k], busy_v[k]}), 32'(5'b11100));
            check($sformatf("midrst w%0d done_act", wait_of[k]), done_v[k], 32'hffff_ffff);
        end
        rst = 1'b0;

        v = '{1'b0, 1'b1, 16'h0077, 16'h7777, 32'd7, 16'h0000, 1'b0};
        start_req(v.rd, v.wr, v.a, v.d, v.act);
        finish_req(v.act);
        check_vec(9, v);
        v = '{1'b1, 1'b0, 16'h0077, 16'h0000, 32'd8, 16'h7777, 1'b0};
        start_req(v.rd, v.wr, v.a, v.d, v.act);
        finish_req(v.act);
        check_vec(10, v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_sequencer.md
# sram_sequencer

Cycle-level sequencer for one asynchronous 16-bit SRAM chip (one instance per chip: RAM1 and RAM2). It accepts a request when the RAM controller raises its per-chip `need_to_work` and the request token differs from the last completed token. It then drives chip-enable, output-enable, write-enable, address and data with fixed setup, pulse and hold phases. On completion it publishes the request token on `done_act`, along with read data on `feedback`, which closes the token handshake in the RAM controller.

## Interface
- `WAIT_CYCLES`, default 1: extra cycles of read access and write pulse, range 0..15.
- `clk` in 1: system clock; all state changes on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `need_to_work` in 1: request from the RAM controller for this chip.
- `mem_rd` in 1: read request qualifier.
- `mem_wr` in 1: write request qualifier; wins over `mem_rd` if both are high.
- `addr` in 16 (`MemAddr`): word address.
- `wdata` in 16 (`MemValue`): write data.
- `mem_act` in 32: request token; `32'hffffffff` is reserved and never issued.
- `done_act` out 32: token of the last completed access.
- `feedback` out 16 (`MemValue`): data from the last completed read.
- `busy` out 1: high whenever the state is not IDLE.
- `ram_addr` out 18: chip address, `{2'b00, addr}`.
- `ram_data` inout 16: chip data bus; Z unless the state is WR_SETUP, WR_PULSE or WR_HOLD.
- `ram_en_n` out 1: chip enable, active-low.
- `ram_oe_n` out 1: output enable, active-low.
- `ram_we_n` out 1: write enable, active-low.

## Operation
- **States:** IDLE, RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD, DONE. There is a 4-bit down-counter `cnt`.
- **IDLE accept condition:** `need_to_work && (mem_rd || mem_wr) && mem_act != done_act`.
- **On accept:** latch `addr`, `wdata`, `mem_act` and the op (write if `mem_wr`).
  - Read: go to RD_WAIT with `cnt=WAIT_CYCLES`.
  - Write: go to WR_SETUP.
- **IDLE without accept:** stay in IDLE.
- **RD_WAIT:**
  - Drive `en_n=0`, `oe_n=0`, `we_n=1`, bus Z.
  - If `cnt!=0`, decrement.
  - If `cnt==0`, capture `ram_data` into `feedback`, set `done_act` to the latched token, and go to DONE.
- **WR_SETUP:**
  - Drive `en_n=0`, `oe_n=1`, `we_n=1`, and drive the latched data.
  - Go to WR_PULSE with `cnt=WAIT_CYCLES`.
- **WR_PULSE:**
  - Drive `en_n=0`, `we_n=0`, and keep driving data.
  - If `cnt!=0`, decrement; otherwise go to WR_HOLD.
- **WR_HOLD:**
  - Drive `en_n=0`, `we_n=1`, and keep driving data.
  - Set `done_act` to the latched token and go to DONE. `feedback` is unchanged.
- **DONE:** all strobes high, bus Z; go to IDLE. This is a bus-turnaround cycle.
- **Request inputs outside IDLE:** ignored. Input changes after accept do not affect the access in flight.
- **Registered outputs:** all chip strobes and `ram_addr` are registered, so there are no combinational glitches on chip pins.
- **Reset values:**
  - state IDLE, `cnt=0`
  - `done_act=32'hffffffff`, `feedback=16'h0000`, `busy=0`
  - `ram_addr=0`, `ram_en_n=1`, `ram_oe_n=1`, `ram_we_n=1`, bus Z
- **Reset mid-access:** abort immediately. `done_act` is not updated, so the requester's token still mismatches and the controller re-requests after reset.

## Timing
Let E0 be the rising edge on which the request is accepted.

- **Read:**
  - Strobes are active from E0 to E(WAIT+1).
  - Data is sampled at E(WAIT+1); `done_act` and `feedback` are valid after E(WAIT+1).
  - IDLE after E(WAIT+2); next accept earliest at E(WAIT+3).
  - Throughput: WAIT+3 cycles per read.
- **Write:**
  - Setup: 1 cycle. `we_n` low from E1 to E(WAIT+2), i.e. WAIT+1 cycles.
  - Hold: 1 cycle with data still driven.
  - `done_act` is valid after E(WAIT+3); IDLE after E(WAIT+4).
  - Throughput: WAIT+5 cycles per write.
- **Address stability:** `ram_addr` is stable from E0 until the next accept. Data is driven before `we_n` falls and after it rises.
- **Back-to-back:** a new token presented while the sequencer is in DONE is accepted on the first IDLE cycle.
- **Completed token held:** a token equal to `done_act` is never re-executed, even if `need_to_work` stays high.

## Test plan
- **Reset:** assert `rst` 2 cycles → `done_act=ffffffff`, `feedback=0`, `ram_en_n=ram_oe_n=ram_we_n=1`, bus Z, `busy=0`.
- **Write, WAIT=1:** write `addr=16'h8003`, `wdata=16'hBEEF`, `mem_act=5` → `we_n` low exactly 2 cycles; bus = BEEF from E0+1 through WR_HOLD; `done_act=5` after E4.
- **Read back:** SRAM model returns BEEF at addr 0x8003, read with `mem_act=6` → `feedback=BEEF`, `done_act=6` after E2; `we_n` never low.
- **Repeated token:** hold `need_to_work` with `mem_act=6` after completion → no further strobe activity. `mem_rd` and `mem_wr` both high with `act=7` → write performed.
- **Reset mid-write:** assert `rst` during WR_PULSE → next cycle all strobes high, bus Z, `done_act=ffffffff`. Reissue `act=7` → full write completes.
- **WAIT=0 and WAIT=15:** read latency 1 and 16 edges to `done_act`; write pulse 1 and 16 cycles; no overlap between `oe_n` low and bus drive.
